// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator scheduler: datapath width, FSM encoding
// and the round-robin pointer helper.
package accum_pkg;

    localparam int ACC_WIDTH = 26;
    localparam int GAP_W     = 4;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_ISSUE = 3'd1;
    localparam logic [2:0] ENC_WAIT  = 3'd2;
    localparam logic [2:0] ENC_ACK   = 3'd3;
    localparam logic [2:0] ENC_GAP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ISSUE = ENC_ISSUE,
        ST_WAIT  = ENC_WAIT,
        ST_ACK   = ENC_ACK,
        ST_GAP   = ENC_GAP
    } state_t;

    // Pointer value after granting idx: the requester just above idx gets top priority.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr and wraps,
// so the first pending requester at or above ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_valid && req[cand]) begin
                any_valid   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/accum_scheduler.sv
// Time-shares one external accumulator among NUM_REQ requesters: arbitrate, issue a
// single sample pulse, capture the updated accumulator value and return it with an ack.
module accum_scheduler
    import accum_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = ACC_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       GlobalReset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   inc_bus,
    input  logic [WIDTH-1:0]           acc_out,
    output logic                       sample,
    output logic [WIDTH-1:0]           increment,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           result,
    output logic                       result_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output state_t                     dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a requester raises req[i] with its increment on inc_bus and holds both
    // until ack[i] pulses for one cycle; req is only looked at in IDLE, so once granted
    // the transaction completes regardless of req, and a req still high in IDLE is new.

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [GAP_W-1:0]     gap_cnt;
    logic [NUM_REQ-1:0]   grant_oh;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [WIDTH-1:0]     win_inc;
    logic [IDX_W-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    always_comb begin
        win_inc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) win_inc = inc_bus[i*WIDTH +: WIDTH];
        end
    end

    assign next_ptr  = IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            gap_cnt      <= '0;
            grant_oh     <= '0;
            sample       <= 1'b0;
            increment    <= '0;
            ack          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            grant_id     <= '0;
        end else begin
            sample       <= 1'b0;
            ack          <= '0;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_id  <= arb_idx;
                        grant_oh  <= arb_grant;
                        increment <= win_inc;
                        rr_ptr    <= next_ptr;
                        sample    <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The accumulator adds at the end of this cycle; its new Out is visible in WAIT.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    result       <= acc_out;
                    ack          <= grant_oh;
                    result_valid <= 1'b1;
                    state        <= ST_ACK;
                end
                ST_ACK: begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_W'(GAP_CYCLES);
                        state   <= ST_GAP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt <= 1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
